spi_word_receiver: RTL

//  Receive end of the team's serial word link: deserializes 16-bit words sent MSB-first on a

---
 rtl/spi_word_receiver.sv | 128 ++++++++++++
 1 files changed

// File: rtl/spi_word_receiver.sv
// Serial word receiver: deserializes MSB-first framed words into a show-ahead FIFO,
// with sticky framing-error and overflow status.
module spi_word_receiver #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     sclk_i,
  input  logic                     rst_i,
  input  logic                     frame_valid_i,
  input  logic                     serial_in_i,
  input  logic                     rd_en_i,
  input  logic                     err_clr_i,
  output logic [WORD_W-1:0]        rd_data_o,
  output logic                     rd_valid_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     frame_err_o,
  output logic                     overflow_o
);

  localparam int unsigned CntW  = $clog2(WORD_W);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntFW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  // Completed word waits one edge in shift_q before entering the FIFO.
  logic                push_q, push_d;
  logic                frame_err_q, frame_err_d;
  logic                overflow_q, overflow_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntFW-1:0]    count_q, count_d;
  logic [WORD_W-1:0]   mem_q [DEPTH];

  logic frame_set;
  logic full, pop, push_ok, ovf_set;

  // Frame FSM next-state: header, data shift, post-word gap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_valid_i) begin
          state_d = StShift;
          cnt_d   = CntW'(WORD_W - 1);
        end
      end
      StShift: begin
        if (!frame_valid_i) begin
          state_d   = StIdle;
          frame_set = 1'b1;
        end else begin
          shift_d[cnt_q] = serial_in_i;
          if (cnt_q == '0) begin
            push_d  = 1'b1;
            state_d = StGap;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StGap: begin
        if (!frame_valid_i) state_d = StIdle;
        else                frame_set = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO bookkeeping and sticky status next-state.
  always_comb begin
    full     = (count_q == CntFW'(DEPTH));
    pop      = rd_en_i && (count_q != '0);
    push_ok  = push_q && (!full || pop);
    ovf_set  = push_q && full && !pop;
    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CntFW'(1);
      2'b01:   count_d = count_q - CntFW'(1);
      default: count_d = count_q;
    endcase
    // Set event wins over a simultaneous clear.
    frame_err_d = frame_set | (frame_err_q & ~err_clr_i);
    overflow_d  = ovf_set | (overflow_q & ~err_clr_i);
  end

  // State, shifter and FIFO registers.
  always_ff @(posedge sclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign rd_valid_o   = (count_q != '0);
  assign rd_data_o    = rd_valid_o ? mem_q[rd_ptr_q] : '0;
  assign fifo_count_o = count_q;
  assign frame_err_o  = frame_err_q;
  assign overflow_o   = overflow_q;

endmodule
